mmio_button_ctrl: RTL and testbench

- Memory-mapped I/O controller between the processor's data-memory port and the data RAM.
- Decodes the button and output addresses and debounces an asynchronous push-button input.
- Latches presses into a clear-on-read flag, counts presses, and holds the output register.
- All other addresses pass through to RAM unchanged. This replaces the ad-hoc button/output muxing currently placed around the processor and RAM.

---
 rtl/mmio_pkg.sv | 35 +++
 rtl/button_debouncer.sv | 49 ++++
 rtl/mmio_button_ctrl.sv | 107 ++++++++++
 tb/tb_mmio_button_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Purpose: shared address map and register field positions for the MMIO button/output block.
// Latency: n/a (constants and a pure decode function only).
// Backpressure: n/a.
package mmio_pkg;

    localparam logic [31:0] BTN_ADDR = 32'd1000;
    localparam logic [31:0] CNT_ADDR = 32'd1001;
    localparam logic [31:0] OUT_ADDR = 32'd2000;

    // Bit positions inside the word returned by a BTN_ADDR read
    localparam int BTN_FLAG_BIT  = 0;
    localparam int BTN_LEVEL_BIT = 1;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_BTN  = 2'd1,
        SEL_CNT  = 2'd2,
        SEL_OUT  = 2'd3
    } mmio_sel_e;

    // Full 32-bit compare; anything that does not match belongs to RAM
    function automatic mmio_sel_e mmio_decode(input logic [31:0] addr);
        mmio_sel_e sel;
        sel = SEL_NONE;
        if (addr == BTN_ADDR) begin
            sel = SEL_BTN;
        end else if (addr == CNT_ADDR) begin
            sel = SEL_CNT;
        end else if (addr == OUT_ADDR) begin
            sel = SEL_OUT;
        end
        return sel;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Purpose: 2-flop synchronizer plus stability counter for an asynchronous push-button.
// Latency: a raw edge stable before edge 1 moves level at edge 2+DEBOUNCE_CYCLES.
// Backpressure: none; press_pulse is a single-cycle strobe that must be consumed at once.
// Ports: clock, reset (async active-low), raw (async button level);
//        level (debounced level), press_pulse (high in the cycle whose edge takes level 0->1).
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press_pulse
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic          sync_out;
    logic [CW-1:0] deb_cnt;
    logic          flip;

    assign sync_out = sync[1];

    // Level flips on the edge where the mismatch has persisted DEBOUNCE_CYCLES samples
    assign flip        = (sync_out != level) && (deb_cnt == CNT_LAST);
    // Pulse is combinational so the parent can set its flag on the very edge level rises
    assign press_pulse = flip && sync_out;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync    <= 2'b00;
            level   <= 1'b0;
            deb_cnt <= '0;
        end else begin
            sync <= {sync[0], raw};
            if (sync_out == level) begin
                deb_cnt <= '0;
            end else if (flip) begin
                level   <= sync_out;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mmio_button_ctrl.sv
// Purpose: MMIO decode between processor data port and RAM: button flag/counter and output register.
// Latency: reads return one cycle after the address, matching the registered RAM output.
// Backpressure: none; every access completes in one cycle, non-MMIO traffic passes straight through.
// Ports: clock, reset (async active-low); address_dmem/wren/data from the processor;
//        ram_q from RAM, ram_wren to RAM; q_dmem to the processor; button_raw in; out_reg out.
module mmio_button_ctrl
    import mmio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int OUT_W           = 8,
    parameter int CNT_W           = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      address_dmem,
    input  logic             wren,
    input  logic [31:0]      data,
    input  logic [31:0]      ram_q,
    output logic             ram_wren,
    output logic [31:0]      q_dmem,
    input  logic             button_raw,
    output logic [OUT_W-1:0] out_reg
);

    mmio_sel_e        sel;
    logic             is_mmio;
    logic             db_level;
    logic             press_pulse;
    logic             press_flag;
    logic [CNT_W-1:0] press_count;
    logic [31:0]      rd_val;
    logic [31:0]      q_reg;
    logic             sel_reg;
    logic             rd_btn;
    logic             wr_cnt;
    logic             wr_out;
    logic             unused_data;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clock       (clock),
        .reset       (reset),
        .raw         (button_raw),
        .level       (db_level),
        .press_pulse (press_pulse)
    );

    assign sel      = mmio_decode(address_dmem);
    assign is_mmio  = (sel != SEL_NONE);
    assign ram_wren = wren && !is_mmio;
    assign rd_btn   = (sel == SEL_BTN) && !wren;
    assign wr_cnt   = (sel == SEL_CNT) && wren;
    assign wr_out   = (sel == SEL_OUT) && wren;

    // Only the low OUT_W bits of a write reach the output register
    assign unused_data = &{1'b0, data[31:OUT_W]};

    // Register value as seen before this edge's updates
    always_comb begin
        rd_val = '0;
        case (sel)
            SEL_BTN: begin
                rd_val[BTN_FLAG_BIT]  = press_flag;
                rd_val[BTN_LEVEL_BIT] = db_level;
            end
            SEL_CNT: rd_val = 32'(press_count);
            SEL_OUT: rd_val = 32'(out_reg);
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            press_flag  <= 1'b0;
            press_count <= '0;
            out_reg     <= '0;
            q_reg       <= '0;
            sel_reg     <= 1'b0;
        end else begin
            sel_reg <= is_mmio && !wren;
            if (is_mmio && !wren) begin
                q_reg <= rd_val;
            end

            // A press on the same edge as a clearing read wins, so no press is lost
            if (press_pulse) begin
                press_flag <= 1'b1;
            end else if (rd_btn) begin
                press_flag <= 1'b0;
            end

            if (wr_cnt) begin
                press_count <= press_pulse ? CNT_W'(1) : '0;
            end else if (press_pulse) begin
                press_count <= press_count + 1'b1;
            end

            if (wr_out) begin
                out_reg <= data[OUT_W-1:0];
            end
        end
    end

    assign q_dmem = sel_reg ? q_reg : ram_q;

endmodule

// File: tb/tb_mmio_button_ctrl.sv
// Purpose: directed self-checking bench for mmio_button_ctrl with DEBOUNCE_CYCLES=4, OUT_W=8.
// Latency: inputs driven 1 time unit after each rising edge, outputs sampled at that same point.
// Backpressure: n/a.
module tb_mmio_button_ctrl;
    import mmio_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] address_dmem;
    logic        wren;
    logic [31:0] data;
    logic [31:0] ram_q;
    logic        ram_wren;
    logic [31:0] q_dmem;
    logic        button_raw;
    logic [7:0]  out_reg;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    mmio_button_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .OUT_W          (8),
        .CNT_W          (16)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .wren         (wren),
        .data         (data),
        .ram_q        (ram_q),
        .ram_wren     (ram_wren),
        .q_dmem       (q_dmem),
        .button_raw   (button_raw),
        .out_reg      (out_reg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic rd(input logic [31:0] a);
        address_dmem = a;
        wren         = 1'b0;
        tick();
    endtask

    task automatic idle(input int n);
        address_dmem = 32'd5;
        wren         = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        address_dmem = 32'd5;
        wren         = 1'b1;
        data         = 32'd0;
        ram_q        = 32'hDEAD_BEEF;
        button_raw   = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("reset_q_dmem", q_dmem, 32'hDEAD_BEEF);
        chk("reset_out_reg", 32'(out_reg), 32'h0);
        chk("ram_wren_follow1", 32'(ram_wren), 32'h1);
        wren = 1'b0;
        #1;
        chk("ram_wren_follow0", 32'(ram_wren), 32'h0);
        tick();
        tick();
        reset = 1'b1;

        // Plain RAM read
        rd(32'd5);
        chk("ram_read", q_dmem, 32'hDEAD_BEEF);
        ram_q = 32'h1234_5678;
        #1;
        chk("ram_passthru", q_dmem, 32'h1234_5678);

        // Short glitch: three raw cycles never qualify
        button_raw = 1'b1;
        idle(3);
        button_raw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd(BTN_ADDR);
            chk("glitch_btn", q_dmem, 32'h0);
        end
        rd(CNT_ADDR);
        chk("glitch_cnt", q_dmem, 32'h0);

        // Press: reads at edges 1..6 see level 0, edge 7 sees level and flag
        button_raw = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            rd(BTN_ADDR);
            chk("press_pre", q_dmem, 32'h0);
        end
        rd(BTN_ADDR);
        chk("press_first", q_dmem, 32'h3);
        rd(BTN_ADDR);
        chk("press_cleared", q_dmem, 32'h2);
        rd(CNT_ADDR);
        chk("press_cnt1", q_dmem, 32'h1);
        button_raw = 1'b0;
        idle(10);

        // Output register write
        address_dmem = OUT_ADDR;
        wren         = 1'b1;
        data         = 32'h0000_01A5;
        #1;
        chk("out_wr_ram_wren", 32'(ram_wren), 32'h0);
        tick();
        wren = 1'b0;
        chk("out_reg_val", 32'(out_reg), 32'h0000_00A5);
        chk("out_wr_q_is_ram", q_dmem, 32'h1234_5678);
        rd(OUT_ADDR);
        chk("out_rd", q_dmem, 32'h0000_00A5);
        address_dmem = 32'd5;
        wren         = 1'b1;
        #1;
        chk("ram_wr_pass", 32'(ram_wren), 32'h1);
        wren = 1'b0;

        // Clear-on-read coinciding with the press edge (edge 6)
        button_raw = 1'b1;
        idle(5);
        rd(BTN_ADDR);
        chk("same_edge_old", q_dmem, 32'h0);
        rd(BTN_ADDR);
        chk("same_edge_kept", q_dmem, 32'h3);
        rd(CNT_ADDR);
        chk("same_edge_cnt", q_dmem, 32'h2);
        button_raw = 1'b0;
        idle(10);

        // Five more presses, then clear the counter
        repeat (5) begin
            button_raw = 1'b1;
            idle(8);
            button_raw = 1'b0;
            idle(8);
        end
        rd(CNT_ADDR);
        chk("cnt_seven", q_dmem, 32'h7);
        address_dmem = BTN_ADDR;
        wren         = 1'b1;
        data         = 32'h0;
        #1;
        chk("btn_wr_ram_wren", 32'(ram_wren), 32'h0);
        tick();
        wren = 1'b0;
        rd(BTN_ADDR);
        chk("btn_wr_ignored", q_dmem, 32'h1);
        address_dmem = CNT_ADDR;
        wren         = 1'b1;
        #1;
        chk("cnt_wr_ram_wren", 32'(ram_wren), 32'h0);
        tick();
        wren = 1'b0;
        rd(CNT_ADDR);
        chk("cnt_cleared", q_dmem, 32'h0);

        // Reset in the middle of a debounce with a pending MMIO read
        button_raw = 1'b1;
        idle(3);
        rd(OUT_ADDR);
        chk("pre_reset_out", q_dmem, 32'h0000_00A5);
        #2 reset = 1'b0;
        #1;
        chk("mid_reset_q", q_dmem, 32'h1234_5678);
        chk("mid_reset_out", 32'(out_reg), 32'h0);
        idle(2);
        reset = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            rd(BTN_ADDR);
            chk("requal_pre", q_dmem, 32'h0);
        end
        rd(BTN_ADDR);
        chk("requal_press", q_dmem, 32'h3);
        rd(CNT_ADDR);
        chk("requal_cnt", q_dmem, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
